// File: rtl/msdap_pkg.sv
// msdap_pkg: shared types and table field positions for the MSDAP convolution engine
package msdap_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB} op_t;
  typedef struct packed {
    op_t  op;
    logic shift;
  } step_t;
  localparam int SIGN_BIT = 8;
  localparam int DLY_W = 8;
  localparam int RJ_W = 8;
  localparam int CFG_W = 9;
  localparam logic SEL_RJ = 1'b0;
  localparam logic SEL_COEFF = 1'b1;
endpackage

// File: rtl/msdap_conv_lane.sv
// msdap_conv_lane: one channel history store, registered history read and accumulator
module msdap_conv_lane
  import msdap_pkg::*;
#(
  parameter int DW = 16,
  parameter int ORDER = 256,
  parameter int ACC_W = 40,
  parameter int FRAC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(ORDER)-1:0] wp,
  input  logic [DW-1:0]            din,
  input  logic [DLY_W-1:0]         k,
  input  step_t                    step,
  input  logic                     done,
  output logic [ACC_W-1:0]         acc
);
  localparam int AW = $clog2(ORDER);
  logic [DW-1:0] hist [ORDER];
  logic [DW-1:0] rd;
  step_t sq;
  logic [ACC_W-1:0] ext, sum;
  always_comb begin
    ext = {{(ACC_W-DW){rd[DW-1]}}, rd} << FRAC;
    sum = acc + (sq.op == OP_ADD ? ext : sq.op == OP_SUB ? -ext : '0);
  end
  // the step issued last cycle is applied now, alongside its registered history read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ORDER; i++) hist[i] <= '0;
      rd <= '0;
      sq <= '0;
      acc <= '0;
    end else begin
      if (we) hist[wp + AW'(1)] <= din;
      rd <= hist[wp - AW'(k)];
      sq <= step;
      acc <= done ? '0 : sq.shift ? {sum[ACC_W-1], sum[ACC_W-1:1]} : sum;
    end
  end
endmodule

// File: rtl/msdap_conv_engine.sv
// msdap_conv_engine: RJ/coeff tables and sequencer driving NCH lock-step convolution lanes
module msdap_conv_engine
  import msdap_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW = 16,
  parameter int ORDER = 256,
  parameter int NRJ = 16,
  parameter int NCOEFF = 512,
  parameter int ACC_W = 40,
  parameter int FRAC = 16
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [CFG_W-1:0]     cfg_addr,
  input  logic [CFG_W-1:0]     cfg_wdata,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [NCH*DW-1:0]    s_data,
  output logic                 r_valid,
  output logic [NCH*ACC_W-1:0] r_data,
  output logic                 busy,
  output logic                 err
);
  localparam int AW = $clog2(ORDER);
  localparam int GW = $clog2(NRJ);
  localparam int CW = $clog2(NCOEFF);
  localparam int PW = $clog2(NCOEFF + 1);
  state_t state;
  logic [RJ_W-1:0] rj [NRJ];
  logic [CFG_W-1:0] coeff [NCOEFF];
  logic [GW-1:0] g;
  logic [RJ_W-1:0] cnt, rjv;
  logic [PW-1:0] p;
  logic [AW-1:0] wp;
  logic [CFG_W-1:0] cv;
  logic have, last, accept;
  step_t step;
  logic [NCH*ACC_W-1:0] acc_all;
  assign s_ready = state == IDLE && !cfg_we;
  assign busy = state != IDLE;
  assign accept = s_valid && s_ready && !clear;
  always_comb begin
    rjv = rj[g];
    have = p < PW'(NCOEFF);
    cv = coeff[p[CW-1:0]];
    last = rjv == '0 || cnt == rjv - 8'd1;
    step.op = state != RUN || rjv == '0 || !have ? OP_NONE : cv[SIGN_BIT] ? OP_SUB : OP_ADD;
    step.shift = state == RUN && last;
  end
  always_ff @(posedge sclk) begin
    if (reset) begin
      state <= IDLE;
      g <= '0;
      cnt <= '0;
      p <= '0;
      wp <= '0;
      err <= 1'b0;
      r_valid <= 1'b0;
      r_data <= '0;
      for (int i = 0; i < NRJ; i++) rj[i] <= '0;
      for (int i = 0; i < NCOEFF; i++) coeff[i] <= '0;
    end else if (clear) begin
      state <= IDLE;
      g <= '0;
      cnt <= '0;
      p <= '0;
      wp <= '0;
      err <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (cfg_we && state == IDLE && cfg_sel == SEL_RJ) rj[cfg_addr[GW-1:0]] <= cfg_wdata[RJ_W-1:0];
      if (cfg_we && state == IDLE && cfg_sel == SEL_COEFF && int'(cfg_addr) < NCOEFF)
        coeff[cfg_addr[CW-1:0]] <= cfg_wdata;
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          wp <= wp + AW'(1);
          g <= '0;
          cnt <= '0;
          p <= '0;
        end
        RUN: begin
          // once the coefficient table is exhausted, terms drop out but shifts continue
          err <= err | (rjv != '0 && !have);
          p <= p + PW'(rjv != '0 && have);
          cnt <= last ? '0 : cnt + 8'd1;
          g <= g + GW'(last);
          state <= last && g == GW'(NRJ - 1) ? FLUSH : RUN;
        end
        FLUSH: state <= DONE;
        default: begin
          r_data <= acc_all;
          r_valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_lane
    msdap_conv_lane #(.DW(DW), .ORDER(ORDER), .ACC_W(ACC_W), .FRAC(FRAC)) u_lane (
      .clk(sclk),
      .rst(reset || clear),
      .we(accept),
      .wp(wp),
      .din(s_data[c*DW +: DW]),
      .k(cv[DLY_W-1:0]),
      .step(step),
      .done(state == DONE),
      .acc(acc_all[c*ACC_W +: ACC_W])
    );
  end
endmodule
